// File: rtl/ntt_sequencer.sv
// Start/busy/done sequencer for the NTT rowcalc array: issues operand reads, drains the
// array pipeline, strobes result capture and holds a valid/ready result toward the consumer.
module ntt_sequencer #(
  parameter int N        = 64,
  parameter int AW       = 6,
  parameter int PIPE_LAT = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW:0]   len,
  input  logic          stall,
  input  logic          out_ready,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_addr,
  output logic          array_en,
  output logic          array_valid,
  output logic          array_first,
  output logic          array_last,
  output logic          capture,
  output logic          out_valid,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_DRAIN   = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_HOLD    = 3'd4;

  localparam int            DW         = $clog2(PIPE_LAT + 2);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPE_LAT);

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW:0]   len_q, len_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          vld_q, vld_d;
  logic          first_q, first_d;
  logic          last_q, last_d;
  logic          err_q, err_d;
  logic          len_ok;
  logic          idx_is_last;

  assign array_en    = ((state_q == S_ISSUE) || (state_q == S_DRAIN)) && !stall;
  assign mem_rd_en   = (state_q == S_ISSUE) && !stall;
  assign mem_addr    = idx_q;
  // The pending valid/first/last describe the operand read on the previous enabled cycle.
  assign array_valid = array_en && vld_q;
  assign array_first = array_valid && first_q;
  assign array_last  = array_valid && last_q;
  assign capture     = (state_q == S_CAPTURE);
  assign out_valid   = (state_q == S_HOLD);
  assign done        = out_valid && out_ready;
  assign busy        = (state_q != S_IDLE);
  assign err         = err_q;

  assign len_ok      = (len != '0) && (len <= (AW+1)'(N));
  assign idx_is_last = ({1'b0, idx_q} == (len_q - (AW+1)'(1)));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    drain_d = drain_q;
    vld_d   = vld_q;
    first_d = first_q;
    last_d  = last_q;
    err_d   = 1'b0;

    if (array_en) begin
      vld_d   = mem_rd_en;
      first_d = mem_rd_en && (idx_q == '0);
      last_d  = mem_rd_en && idx_is_last;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len_ok) begin
            len_d   = len;
            idx_d   = '0;
            state_d = S_ISSUE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (!stall) begin
          if (idx_is_last) begin
            idx_d   = '0;
            drain_d = '0;
            state_d = S_DRAIN;
          end else begin
            idx_d = idx_q + AW'(1);
          end
        end
      end
      S_DRAIN: begin
        // One cycle for the memory read plus the full rowcalc pipeline depth.
        if (!stall) begin
          if (drain_q == DRAIN_LAST) begin
            state_d = S_CAPTURE;
          end else begin
            drain_d = drain_q + DW'(1);
          end
        end
      end
      S_CAPTURE: state_d = S_HOLD;
      S_HOLD: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      drain_q <= '0;
      vld_q   <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      drain_q <= drain_d;
      vld_q   <= vld_d;
      first_q <= first_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_ntt_sequencer.sv
// Directed bench for ntt_sequencer: an event-timeline model predicts every output per cycle,
// plus literal cycle numbers for the key strobes of each scenario.
module tb_ntt_sequencer;
  localparam int N    = 64;
  localparam int AW   = 6;
  localparam int PL   = 7;
  localparam int MAXC = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   len = '0;
  logic          stall = 1'b0;
  logic          out_ready = 1'b0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic          array_en, array_valid, array_first, array_last;
  logic          capture, out_valid, busy, done, err;

  ntt_sequencer #(.N(N), .AW(AW), .PIPE_LAT(PL)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .stall(stall), .out_ready(out_ready),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .array_en(array_en),
    .array_valid(array_valid), .array_first(array_first), .array_last(array_last),
    .capture(capture), .out_valid(out_valid), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int scen = 0;
  int stall_pat[MAXC], rdy_pat[MAXC], start_pat[MAXC];
  int e_rd[MAXC], e_addr[MAXC], e_en[MAXC], e_val[MAXC], e_first[MAXC], e_last[MAXC];
  int e_cap[MAXC], e_ov[MAXC], e_done[MAXC], e_busy[MAXC], e_err[MAXC];
  int end_t;
  int first_cyc, last_cyc, cap_cyc, done_cyc, rd_count, err_count;

  task automatic chk(input string nm, input int t, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s scen=%0d cyc=%0d got=%0d expected=%0d", nm, scen, t, act, exp);
    end
  endtask

  task automatic clear_pats();
    for (int i = 0; i < MAXC; i++) begin
      stall_pat[i] = 0;
      rdy_pat[i]   = 1;
      start_pat[i] = 0;
    end
    start_pat[0] = 1;
  endtask

  // Walks the transaction as a timeline: issue slots, drain slots, capture, hold.
  task automatic build_model(input int L);
    int t, issued, drained, c;
    int iss_cyc[N];
    for (int i = 0; i < MAXC; i++) begin
      e_rd[i] = 0; e_addr[i] = 0; e_en[i] = 0; e_val[i] = 0; e_first[i] = 0; e_last[i] = 0;
      e_cap[i] = 0; e_ov[i] = 0; e_done[i] = 0; e_busy[i] = 0; e_err[i] = 0;
    end
    if (L < 1 || L > N) begin
      e_err[1] = 1;
      end_t = 1;
      return;
    end
    t = 1; issued = 0;
    while (issued < L && t < MAXC - 4) begin
      e_busy[t] = 1;
      if (stall_pat[t] == 0) begin
        e_en[t] = 1; e_rd[t] = 1; e_addr[t] = issued; iss_cyc[issued] = t; issued++;
      end
      t++;
    end
    drained = 0;
    while (drained < 1 + PL && t < MAXC - 4) begin
      e_busy[t] = 1;
      if (stall_pat[t] == 0) begin
        e_en[t] = 1; drained++;
      end
      t++;
    end
    e_cap[t] = 1; e_busy[t] = 1; t++;
    while (rdy_pat[t] == 0 && t < MAXC - 4) begin
      e_ov[t] = 1; e_busy[t] = 1; t++;
    end
    e_ov[t] = 1; e_done[t] = 1; e_busy[t] = 1;
    end_t = t;
    for (int k = 0; k < L; k++) begin
      c = iss_cyc[k] + 1;
      while (e_en[c] == 0 && c < MAXC - 1) c++;
      e_val[c] = 1;
      if (k == 0) e_first[c] = 1;
      if (k == L - 1) e_last[c] = 1;
    end
  endtask

  task automatic compare(input int t);
    chk("mem_rd_en", t, int'(mem_rd_en), e_rd[t]);
    if (e_rd[t] != 0) chk("mem_addr", t, int'(mem_addr), e_addr[t]);
    chk("array_en", t, int'(array_en), e_en[t]);
    chk("array_valid", t, int'(array_valid), e_val[t]);
    chk("array_first", t, int'(array_first), e_first[t]);
    chk("array_last", t, int'(array_last), e_last[t]);
    chk("capture", t, int'(capture), e_cap[t]);
    chk("out_valid", t, int'(out_valid), e_ov[t]);
    chk("done", t, int'(done), e_done[t]);
    chk("busy", t, int'(busy), e_busy[t]);
    chk("err", t, int'(err), e_err[t]);
    if (array_first && first_cyc < 0) first_cyc = t;
    if (array_last && last_cyc < 0) last_cyc = t;
    if (capture && cap_cyc < 0) cap_cyc = t;
    if (done && done_cyc < 0) done_cyc = t;
    if (mem_rd_en) rd_count++;
    if (err) err_count++;
  endtask

  task automatic all_zero(input string nm);
    chk({nm, "_rd"}, -1, int'(mem_rd_en), 0);
    chk({nm, "_addr"}, -1, int'(mem_addr), 0);
    chk({nm, "_en"}, -1, int'(array_en), 0);
    chk({nm, "_valid"}, -1, int'(array_valid | array_first | array_last), 0);
    chk({nm, "_cap"}, -1, int'(capture | out_valid | done), 0);
    chk({nm, "_busy"}, -1, int'(busy), 0);
    chk({nm, "_err"}, -1, int'(err), 0);
  endtask

  // Caller is positioned 1 time unit after a rising edge; cycle 0 is the start cycle.
  task automatic run(input int L, input int tail, input int abort_at);
    scen++;
    build_model(L);
    first_cyc = -1; last_cyc = -1; cap_cyc = -1; done_cyc = -1; rd_count = 0; err_count = 0;
    len = (AW+1)'(L);
    for (int t = 0; t <= end_t + tail; t++) begin
      start     = (start_pat[t] != 0);
      stall     = (stall_pat[t] != 0);
      out_ready = (rdy_pat[t] != 0);
      @(negedge clk);
      compare(t);
      if (t == abort_at) begin
        rst = 1'b0;
        #1;
        all_zero("abort");
        @(posedge clk); #1;
        all_zero("abort_hold");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; stall = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    stall = 1'b0;
  endtask

  initial begin
    #2;
    all_zero("reset");
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    all_zero("reset_clk");
    rst = 1'b1;
    @(posedge clk); #1;

    // Full length, followed back-to-back by len=1 in the very next idle cycle.
    clear_pats();
    run(64, 0, -1);
    chk("l64_first", 0, first_cyc, 2);
    chk("l64_last", 0, last_cyc, 65);
    chk("l64_capture", 0, cap_cyc, 73);
    chk("l64_done", 0, done_cyc, 74);
    chk("l64_reads", 0, rd_count, 64);

    clear_pats();
    run(1, 3, -1);
    chk("l1_first", 0, first_cyc, 2);
    chk("l1_last", 0, last_cyc, 2);
    chk("l1_capture", 0, cap_cyc, 10);
    chk("l1_reads", 0, rd_count, 1);

    clear_pats();
    stall_pat[5] = 1; stall_pat[6] = 1; stall_pat[7] = 1;
    stall_pat[14] = 1; stall_pat[15] = 1;
    run(8, 3, -1);
    chk("l8s_capture", 0, cap_cyc, 22);
    chk("l8s_last", 0, last_cyc, 12);
    chk("l8s_reads", 0, rd_count, 8);

    clear_pats();
    run(0, 3, -1);
    chk("len0_err", 0, err_count, 1);
    chk("len0_reads", 0, rd_count, 0);
    clear_pats();
    run(65, 3, -1);
    chk("len65_err", 0, err_count, 1);
    chk("len65_reads", 0, rd_count, 0);

    clear_pats();
    for (int i = 14; i <= 23; i++) rdy_pat[i] = 0;
    start_pat[16] = 1;
    stall_pat[18] = 1;
    run(4, 3, -1);
    chk("hold_capture", 0, cap_cyc, 13);
    chk("hold_done", 0, done_cyc, 24);

    clear_pats();
    run(8, 0, 12);
    chk("abort_no_done", 0, done_cyc, -1);
    clear_pats();
    run(4, 3, -1);
    chk("post_rst_capture", 0, cap_cyc, 13);
    chk("post_rst_done", 0, done_cyc, 14);
    chk("post_rst_reads", 0, rd_count, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
